// File: rtl/debug_cmd_pkg.sv
// Shared definitions for the debug host controller.
// Contents:
//   - command codes sent to the target debug unit;
//   - response lengths in bytes for each read command;
//   - FSM state encoding, which is also visible on o_state;
//   - rsp_len(): maps a command code to the number of bytes the target returns.
package debug_cmd_pkg;

    localparam int RSP_W = 9;

    localparam logic [7:0] CMD_WRITE_IM   = 8'd1;
    localparam logic [7:0] CMD_CONTINUOUS = 8'd2;
    localparam logic [7:0] CMD_STEP_MODE  = 8'd3;
    localparam logic [7:0] CMD_READ_BR    = 8'd4;
    localparam logic [7:0] CMD_READ_DM    = 8'd5;
    localparam logic [7:0] CMD_READ_PC    = 8'd6;
    localparam logic [7:0] CMD_STEP       = 8'd7;

    localparam logic [RSP_W-1:0] LEN_PC   = 9'd4;
    localparam logic [RSP_W-1:0] LEN_BR   = 9'd128;
    localparam logic [RSP_W-1:0] LEN_DM   = 9'd128;
    // A step dump is PC, then bank registers, then data memory.
    localparam logic [RSP_W-1:0] LEN_STEP = LEN_PC + LEN_BR + LEN_DM;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND_CMD = 3'd1,
        ST_WAIT_CMD = 3'd2,
        ST_SEND_PL  = 3'd3,
        ST_WAIT_PL  = 3'd4,
        ST_RECV     = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    // Commands without a read-back (including unknown codes) return nothing.
    function automatic logic [RSP_W-1:0] rsp_len(input logic [7:0] cmd);
        case (cmd)
            CMD_READ_BR: rsp_len = LEN_BR;
            CMD_READ_DM: rsp_len = LEN_DM;
            CMD_READ_PC: rsp_len = LEN_PC;
            CMD_STEP:    rsp_len = LEN_STEP;
            default:     rsp_len = '0;
        endcase
    endfunction

endpackage

// File: rtl/debug_host_ctrl_if.sv
// Bus between the debug host controller and its surroundings.
// Signal groups:
//   req : command request from the host (valid/ready).
//   pl  : write-IM payload bytes from the host (valid/ready).
//   tx  : byte + one-cycle start strobe to the UART transmitter, done strobe back.
//   rx  : byte + one-cycle done strobe from the UART receiver.
//   rsp : response bytes to the host, one-cycle valid strobe, last marker.
// Handshake rule for req and pl: a transfer happens on every rising clock edge
// where valid and ready are both high; ready never depends combinationally on
// valid, and the producer holds its data stable while valid is high.
// The "slave" modport is the controller; "master" is the host/UART side.
interface debug_host_ctrl_if #(
    parameter int BYTE   = 8,
    parameter int NB_LEN = 8
);
    logic              i_req_valid;
    logic [BYTE-1:0]   i_req_cmd;
    logic [NB_LEN-1:0] i_req_len;
    logic              o_req_ready;

    logic [BYTE-1:0]   i_pl_data;
    logic              i_pl_valid;
    logic              o_pl_ready;

    logic [BYTE-1:0]   o_tx_data;
    logic              o_tx_start;
    logic              i_tx_done;

    logic [BYTE-1:0]   i_rx_data;
    logic              i_rx_done;

    logic [BYTE-1:0]   o_rsp_data;
    logic              o_rsp_valid;
    logic              o_rsp_last;

    modport slave (
        input  i_req_valid, i_req_cmd, i_req_len, i_pl_data, i_pl_valid,
               i_tx_done, i_rx_data, i_rx_done,
        output o_req_ready, o_pl_ready, o_tx_data, o_tx_start,
               o_rsp_data, o_rsp_valid, o_rsp_last
    );

    modport master (
        output i_req_valid, i_req_cmd, i_req_len, i_pl_data, i_pl_valid,
               i_tx_done, i_rx_data, i_rx_done,
        input  o_req_ready, o_pl_ready, o_tx_data, o_tx_start,
               o_rsp_data, o_rsp_valid, o_rsp_last
    );
endinterface

// File: rtl/debug_timeout_cnt.sv
// Idle-cycle watchdog for the waiting states of the debug host controller.
// Ports:
//   i_clock, i_reset : clock, asynchronous active-low reset.
//   i_enable         : high while the controller waits on a done strobe.
//   i_clear          : a done strobe arrived this cycle; restart the count.
//   o_expired        : this is the TIMEOUT-th consecutive idle cycle.
// Any state change into a waiting state either comes from a non-waiting state
// (enable was low) or coincides with a done strobe (clear), so the count always
// restarts on state changes without needing to see the state itself.
module debug_timeout_cnt #(
    parameter int TIMEOUT = 1000000
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_expired
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            cnt <= '0;
        end else if (!i_enable || i_clear) begin
            cnt <= '0;
        end else if (!o_expired) begin
            cnt <= cnt + 1'b1;
        end
    end

    // A done strobe in the expiry cycle wins over the timeout.
    assign o_expired = i_enable && !i_clear && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/debug_host_ctrl.sv
// Debug host controller: sends a command byte (and for write-IM its payload)
// over a UART transmitter, then collects the response bytes the target returns.
// Ports:
//   i_clock, i_reset : clock, asynchronous active-low reset.
//   bus              : request, payload, UART tx/rx and response signals.
//   o_busy           : controller not in IDLE.
//   o_err_timeout    : one-cycle pulse when a done strobe never arrived.
//   o_state          : current FSM state encoding.
// All outputs are registered; strobes are set on the transition that causes
// them, so each one lasts exactly one cycle.
module debug_host_ctrl
    import debug_cmd_pkg::*;
#(
    parameter int BYTE    = 8,
    parameter int NB_LEN  = 8,
    parameter int NB_RSP  = 9,
    parameter int TIMEOUT = 1000000
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    debug_host_ctrl_if.slave      bus,
    output logic                  o_busy,
    output logic                  o_err_timeout,
    output logic [2:0]            o_state
);
    state_t            state;
    logic [BYTE-1:0]   cmd_q;
    logic [NB_LEN-1:0] len_rem;
    logic [NB_RSP-1:0] rsp_rem;

    logic              req_ready_q;
    logic              pl_ready_q;
    logic [BYTE-1:0]   tx_data_q;
    logic              tx_start_q;
    logic [BYTE-1:0]   rsp_data_q;
    logic              rsp_valid_q;
    logic              rsp_last_q;
    logic              busy_q;
    logic              err_q;

    logic              waiting;
    logic              expired;

    assign waiting = (state == ST_WAIT_CMD) || (state == ST_WAIT_PL) || (state == ST_RECV);

    debug_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_enable  (waiting),
        .i_clear   (bus.i_tx_done || bus.i_rx_done),
        .o_expired (expired)
    );

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state       <= ST_IDLE;
            cmd_q       <= '0;
            len_rem     <= '0;
            rsp_rem     <= '0;
            req_ready_q <= 1'b0;
            pl_ready_q  <= 1'b0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            tx_start_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            err_q       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (bus.i_req_valid && req_ready_q) begin
                        cmd_q       <= bus.i_req_cmd;
                        len_rem     <= bus.i_req_len;
                        rsp_rem     <= NB_RSP'(rsp_len(8'(bus.i_req_cmd)));
                        tx_data_q   <= bus.i_req_cmd;
                        tx_start_q  <= 1'b1;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state       <= ST_SEND_CMD;
                    end
                end
                ST_SEND_CMD: state <= ST_WAIT_CMD;
                ST_WAIT_CMD: begin
                    if (bus.i_tx_done) begin
                        if (cmd_q == BYTE'(CMD_WRITE_IM) && len_rem != '0) begin
                            pl_ready_q <= 1'b1;
                            state      <= ST_SEND_PL;
                        end else if (rsp_rem != '0) begin
                            state <= ST_RECV;
                        end else begin
                            state <= ST_DONE;
                        end
                    end else if (expired) begin
                        err_q       <= 1'b1;
                        busy_q      <= 1'b0;
                        req_ready_q <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                ST_SEND_PL: begin
                    if (bus.i_pl_valid) begin
                        tx_data_q  <= bus.i_pl_data;
                        tx_start_q <= 1'b1;
                        len_rem    <= len_rem - 1'b1;
                        pl_ready_q <= 1'b0;
                        state      <= ST_WAIT_PL;
                    end
                end
                ST_WAIT_PL: begin
                    if (bus.i_tx_done) begin
                        if (len_rem != '0) begin
                            pl_ready_q <= 1'b1;
                            state      <= ST_SEND_PL;
                        end else begin
                            state <= ST_DONE;
                        end
                    end else if (expired) begin
                        err_q       <= 1'b1;
                        busy_q      <= 1'b0;
                        req_ready_q <= 1'b1;
                        len_rem     <= '0;
                        state       <= ST_IDLE;
                    end
                end
                ST_RECV: begin
                    // A byte arriving in the expiry cycle takes priority.
                    if (bus.i_rx_done) begin
                        rsp_data_q  <= bus.i_rx_data;
                        rsp_valid_q <= 1'b1;
                        rsp_rem     <= rsp_rem - 1'b1;
                        if (rsp_rem == NB_RSP'(1)) begin
                            rsp_last_q <= 1'b1;
                            state      <= ST_DONE;
                        end
                    end else if (expired) begin
                        // Partial response is dropped; no last marker.
                        err_q       <= 1'b1;
                        busy_q      <= 1'b0;
                        req_ready_q <= 1'b1;
                        rsp_rem     <= '0;
                        state       <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    busy_q      <= 1'b0;
                    req_ready_q <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: begin
                    busy_q      <= 1'b0;
                    req_ready_q <= 1'b0;
                    pl_ready_q  <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_req_ready = req_ready_q;
    assign bus.o_pl_ready  = pl_ready_q;
    assign bus.o_tx_data   = tx_data_q;
    assign bus.o_tx_start  = tx_start_q;
    assign bus.o_rsp_data  = rsp_data_q;
    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_last  = rsp_last_q;
    assign o_busy          = busy_q;
    assign o_err_timeout   = err_q;
    assign o_state         = state;

endmodule

// File: tb/tb_debug_host_ctrl.sv
// Self-checking bench for debug_host_ctrl: table of commands, hand-written
// corner sequences (PC read, timeout, mid-transfer reset, spurious strobes)
// and randomized commands against a byte-stream reference model.
module tb_debug_host_ctrl;

    localparam int TO = 64;

    logic       i_clock = 1'b0;
    logic       i_reset = 1'b0;
    logic       o_busy;
    logic       o_err_timeout;
    logic [2:0] o_state;

    debug_host_ctrl_if #(.BYTE(8), .NB_LEN(8)) bus ();

    debug_host_ctrl #(.BYTE(8), .NB_LEN(8), .NB_RSP(9), .TIMEOUT(TO)) dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .bus           (bus),
        .o_busy        (o_busy),
        .o_err_timeout (o_err_timeout),
        .o_state       (o_state)
    );

    // ---------------- clock / reset ----------------
    always #5 i_clock = ~i_clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [7:0] exp_tx_q[$];
    logic [7:0] exp_rsp_q[$];
    logic [7:0] pl_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] rx_fixed[$];

    int tx_seen, rsp_seen, last_seen, err_seen, done_seen;
    int last_cyc, idle_cyc, recv_cyc, err_cyc;

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] len;
        int         n_rsp;
        int         n_tx;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name, input logic [31:0] act);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got 0x%0h, expected none", name, act);
    endtask

    // Reference model: response length from the command rules.
    function automatic int model_rsp_len(input logic [7:0] cmd);
        if (cmd == 8'd4 || cmd == 8'd5) return 128;
        if (cmd == 8'd6) return 4;
        if (cmd == 8'd7) return 4 + 128 + 128;
        return 0;
    endfunction

    task automatic clear_obs();
        tx_seen = 0; rsp_seen = 0; last_seen = 0; err_seen = 0; done_seen = 0;
        last_cyc = -1; idle_cyc = -1; recv_cyc = -1; err_cyc = -1;
    endtask

    // ---------------- monitor (samples on the falling edge) ----------------
    always @(negedge i_clock) begin
        cyc++;
        if (i_reset) begin
            if (bus.o_tx_start) begin
                tx_seen++;
                if (exp_tx_q.size() == 0) note_fail("tx_unexpected", bus.o_tx_data);
                else check("tx_byte", bus.o_tx_data, exp_tx_q.pop_front());
            end
            if (bus.o_rsp_valid) begin
                rsp_seen++;
                if (exp_rsp_q.size() == 0) note_fail("rsp_unexpected", bus.o_rsp_data);
                else begin
                    check("rsp_byte", bus.o_rsp_data, exp_rsp_q.pop_front());
                    check("rsp_last_flag", bus.o_rsp_last, exp_rsp_q.size() == 0);
                end
            end
            if (bus.o_rsp_last) begin
                last_seen++;
                last_cyc = cyc;
            end
            if (o_err_timeout) begin
                err_seen++;
                err_cyc = cyc;
            end
            if (o_state == 3'd6) done_seen++;
            if (o_state == 3'd5 && recv_cyc < 0) recv_cyc = cyc;
            if (o_state == 3'd0 && last_cyc >= 0 && idle_cyc < 0) idle_cyc = cyc;
        end
    end

    // ---------------- UART transmitter model ----------------
    always begin
        @(negedge i_clock);
        if (i_reset && bus.o_tx_start) begin
            repeat ($urandom_range(1, 3)) @(negedge i_clock);
            bus.i_tx_done = 1'b1;
            @(negedge i_clock);
            bus.i_tx_done = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_req(input logic [7:0] cmd, input logic [7:0] len);
        int b = 0;
        while (!bus.o_req_ready && b < 50) begin
            @(negedge i_clock);
            b++;
        end
        if (b >= 50) note_fail("req_ready_wait", o_state);
        bus.i_req_cmd   = cmd;
        bus.i_req_len   = len;
        bus.i_req_valid = 1'b1;
        @(negedge i_clock);
        bus.i_req_valid = 1'b0;
        bus.i_req_cmd   = 8'($urandom);
    endtask

    task automatic drive_payload();
        int idx = 0;
        int b = 0;
        while (idx < pl_q.size() && b < 3000) begin
            @(negedge i_clock);
            b++;
            if (bus.o_pl_ready && $urandom_range(0, 3) != 0) begin
                bus.i_pl_data  = pl_q[idx];
                bus.i_pl_valid = 1'b1;
                @(negedge i_clock);
                bus.i_pl_valid = 1'b0;
                bus.i_pl_data  = 8'($urandom);
                idx++;
            end
        end
        if (idx < pl_q.size()) note_fail("payload_wait", idx);
    endtask

    task automatic drive_rx(input int n);
        int b = 0;
        while (o_state != 3'd5 && b < 200) begin
            @(negedge i_clock);
            b++;
        end
        if (o_state != 3'd5) note_fail("recv_wait", o_state);
        else begin
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 2)) @(negedge i_clock);
                bus.i_rx_data = rx_q[i];
                bus.i_rx_done = 1'b1;
                @(negedge i_clock);
                bus.i_rx_done = 1'b0;
                bus.i_rx_data = 8'($urandom);
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int b = 0;
        while (o_state != 3'd0 && b < 200) begin
            @(negedge i_clock);
            b++;
        end
        if (o_state != 3'd0) note_fail(name, o_state);
        repeat (2) @(negedge i_clock);
    endtask

    task automatic run_cmd(input string tag, input logic [7:0] cmd, input logic [7:0] len,
                           input int n_rsp, input int n_tx);
        logic [7:0] b;
        pl_q.delete(); rx_q.delete(); exp_tx_q.delete(); exp_rsp_q.delete();
        clear_obs();
        exp_tx_q.push_back(cmd);
        if (cmd == 8'd1) begin
            for (int i = 0; i < int'(len); i++) begin
                b = (tag == "wim40") ? 8'(i) : 8'($urandom);
                pl_q.push_back(b);
                exp_tx_q.push_back(b);
            end
        end
        for (int i = 0; i < n_rsp; i++) begin
            b = (rx_fixed.size() > i) ? rx_fixed[i] : 8'($urandom);
            rx_q.push_back(b);
            exp_rsp_q.push_back(b);
        end
        send_req(cmd, len);
        fork
            drive_payload();
            begin
                if (n_rsp > 0) drive_rx(n_rsp);
            end
        join
        wait_idle({tag, "_idle_wait"});
        check({tag, "_tx_count"}, tx_seen, n_tx);
        check({tag, "_rsp_count"}, rsp_seen, n_rsp);
        check({tag, "_last_count"}, last_seen, (n_rsp > 0) ? 1 : 0);
        check({tag, "_no_timeout"}, err_seen, 0);
        check({tag, "_done_visited"}, done_seen, 1);
        check({tag, "_tx_left"}, exp_tx_q.size(), 0);
        check({tag, "_rsp_left"}, exp_rsp_q.size(), 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int lat;
        logic [7:0] rc;
        logic [7:0] rl;
        bus.i_req_valid = 1'b0; bus.i_req_cmd = '0; bus.i_req_len = '0;
        bus.i_pl_data = '0; bus.i_pl_valid = 1'b0;
        bus.i_tx_done = 1'b0; bus.i_rx_data = '0; bus.i_rx_done = 1'b0;
        clear_obs();

        vecs[0]  = '{cmd: 8'd6,  len: 8'd0,  n_rsp: 4,   n_tx: 1};
        vecs[1]  = '{cmd: 8'd4,  len: 8'd0,  n_rsp: 128, n_tx: 1};
        vecs[2]  = '{cmd: 8'd5,  len: 8'd9,  n_rsp: 128, n_tx: 1};
        vecs[3]  = '{cmd: 8'd7,  len: 8'd0,  n_rsp: 260, n_tx: 1};
        vecs[4]  = '{cmd: 8'd1,  len: 8'd40, n_rsp: 0,   n_tx: 41};
        vecs[5]  = '{cmd: 8'd1,  len: 8'd0,  n_rsp: 0,   n_tx: 1};
        vecs[6]  = '{cmd: 8'd1,  len: 8'd3,  n_rsp: 0,   n_tx: 4};
        vecs[7]  = '{cmd: 8'd2,  len: 8'd5,  n_rsp: 0,   n_tx: 1};
        vecs[8]  = '{cmd: 8'd3,  len: 8'd0,  n_rsp: 0,   n_tx: 1};
        vecs[9]  = '{cmd: 8'd9,  len: 8'd0,  n_rsp: 0,   n_tx: 1};
        vecs[10] = '{cmd: 8'd0,  len: 8'd7,  n_rsp: 0,   n_tx: 1};
        vecs[11] = '{cmd: 8'hff, len: 8'd0,  n_rsp: 0,   n_tx: 1};

        // Reset state while held in reset, then release.
        repeat (3) @(negedge i_clock);
        check("reset_outputs", {bus.o_req_ready, bus.o_pl_ready, bus.o_tx_start, bus.o_tx_data,
                                bus.o_rsp_valid, bus.o_rsp_last, bus.o_rsp_data, o_busy,
                                o_err_timeout, o_state}, 0);
        i_reset = 1'b1;
        #1 check("req_ready_before_edge", bus.o_req_ready, 0);
        @(negedge i_clock);
        check("req_ready_after_edge", bus.o_req_ready, 1);
        check("busy_idle", o_busy, 0);

        // Spurious strobes in IDLE.
        clear_obs();
        bus.i_rx_data = 8'h5a; bus.i_rx_done = 1'b1; bus.i_tx_done = 1'b1;
        @(negedge i_clock);
        bus.i_rx_done = 1'b0; bus.i_tx_done = 1'b0;
        repeat (3) @(negedge i_clock);
        check("spurious_rx_no_rsp", rsp_seen, 0);
        check("spurious_state_idle", o_state, 0);

        // Table-driven commands.
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].cmd == 8'd1 && vecs[i].len == 8'd40)
                run_cmd("wim40", vecs[i].cmd, vecs[i].len, vecs[i].n_rsp, vecs[i].n_tx);
            else
                run_cmd($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].len, vecs[i].n_rsp, vecs[i].n_tx);
        end

        // PC read with fixed bytes; IDLE one cycle after the last response byte.
        rx_fixed = '{8'h00, 8'h00, 8'h00, 8'h10};
        run_cmd("pc_fixed", 8'd6, 8'd0, 4, 1);
        rx_fixed.delete();
        check("pc_idle_latency", idle_cyc - last_cyc, 1);

        // Timeout while waiting for response bytes.
        exp_tx_q.delete(); exp_rsp_q.delete(); clear_obs();
        exp_tx_q.push_back(8'd4);
        send_req(8'd4, 8'd0);
        for (int b = 0; b < TO + 200 && err_seen == 0; b++) @(negedge i_clock);
        repeat (3) @(negedge i_clock);
        check("to_pulse_count", err_seen, 1);
        check("to_state_idle", o_state, 0);
        check("to_busy", o_busy, 0);
        check("to_no_last", last_seen, 0);
        check("to_no_rsp", rsp_seen, 0);
        lat = err_cyc - recv_cyc;
        check("to_latency_in_range", (recv_cyc >= 0 && lat >= TO && lat <= TO + 2), 1);
        run_cmd("after_to", 8'd6, 8'd0, 4, 1);

        // Reset after 50 bytes of a data-memory read.
        pl_q.delete(); rx_q.delete(); exp_tx_q.delete(); exp_rsp_q.delete(); clear_obs();
        exp_tx_q.push_back(8'd5);
        for (int i = 0; i < 128; i++) begin
            rx_q.push_back(8'($urandom));
            exp_rsp_q.push_back(rx_q[i]);
        end
        send_req(8'd5, 8'd0);
        drive_rx(50);
        @(negedge i_clock);
        check("rst_mid_rsp_count", rsp_seen, 50);
        #2 i_reset = 1'b0;
        #1 check("rst_mid_outputs", {bus.o_req_ready, bus.o_pl_ready, bus.o_tx_start, bus.o_tx_data,
                                     bus.o_rsp_valid, bus.o_rsp_last, bus.o_rsp_data, o_busy,
                                     o_err_timeout, o_state}, 0);
        exp_rsp_q.delete();
        repeat (3) @(negedge i_clock);
        i_reset = 1'b1;
        repeat (3) @(negedge i_clock);
        check("rst_mid_no_strobes", rsp_seen + last_seen + err_seen, 50);
        run_cmd("dm_after_rst", 8'd5, 8'd0, 128, 1);

        // Randomized commands against the model.
        for (int i = 0; i < 12; i++) begin
            rc = 8'($urandom_range(0, 9));
            rl = (rc == 8'd1) ? 8'($urandom_range(0, 12)) : 8'($urandom_range(0, 255));
            run_cmd($sformatf("rand%0d", i), rc, rl, model_rsp_len(rc),
                    1 + ((rc == 8'd1) ? int'(rl) : 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
